// File: rtl/ex_iter_div_if.sv
// Decode-to-execute bundle for ex_iter_div: instruction/operand inputs plus
// the result, forwarding and stall outputs. master = decode side, slave = execute stage.
interface ex_iter_div_if #(
  parameter int DATA_W = 32
);
  logic              flush_i;
  logic [7:0]        aluop_i;
  logic [2:0]        alusel_i;
  logic [DATA_W-1:0] reg1_i;
  logic [DATA_W-1:0] reg2_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [DATA_W-1:0] wdata_o;
  logic              stallreq_o;

  modport master (
    output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    input  wd_o, wreg_o, wdata_o, stallreq_o
  );

  modport slave (
    input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
    output wd_o, wreg_o, wdata_o, stallreq_o
  );
endinterface

// File: rtl/ex_iter_div.sv
// Execute stage: single-cycle logic/shift/arith plus an iterative restoring divider
// that stalls the pipeline. Define EX_SIGNED_DIV_EN to add signed DIV (0x1A) / REM (0x1D).
module ex_iter_div #(
  parameter int DATA_W    = 32,
  parameter int DIV_CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  ex_iter_div_if.slave ex
);

  localparam logic [2:0] SEL_NOP   = 3'd0;
  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd3;
  localparam logic [2:0] SEL_DIV   = 3'd4;

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_DIVU = 8'h1B;
  localparam logic [7:0] OP_REMU = 8'h1C;
`ifdef EX_SIGNED_DIV_EN
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_REM  = 8'h1D;
`endif

  localparam logic [DATA_W-1:0]    ZERO_W   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0]    ONES_W   = {DATA_W{1'b1}};
  localparam logic [DIV_CNT_W-1:0] CNT_ZERO = {DIV_CNT_W{1'b0}};
  localparam logic [DIV_CNT_W-1:0] CNT_ONE  = {{(DIV_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [DIV_CNT_W-1:0] cnt_r, cnt_s;
  logic [DATA_W-1:0]    quo_r, quo_s, rem_r, rem_s, dvsr_r, dvsr_s;
  logic                 op_rem_r, op_rem_s, neg_q_r, neg_q_s, neg_rem_r, neg_rem_s;

  logic                 is_div_s, sgn_op_s, is_rem_op_s, div_start_s;
  logic [DATA_W-1:0]    dvnd_abs_s, dvsr_abs_s, alu_s, quo_res_s, rem_res_s;
  logic [DATA_W:0]      shl_s, diff_s;
  logic [4:0]           shamt_s;

  logic [4:0]           wd_s;
  logic                 wreg_s, stall_s;
  logic [DATA_W-1:0]    wdata_s;

  // Divide opcode decode; signed ops work on magnitudes and fix signs at the end
  always_comb begin
    is_div_s    = 1'b0;
    sgn_op_s    = 1'b0;
    is_rem_op_s = 1'b0;
    if (ex.alusel_i == SEL_DIV) begin
      case (ex.aluop_i)
        OP_DIVU: is_div_s = 1'b1;
        OP_REMU: begin is_div_s = 1'b1; is_rem_op_s = 1'b1; end
`ifdef EX_SIGNED_DIV_EN
        OP_DIV:  begin is_div_s = 1'b1; sgn_op_s = 1'b1; end
        OP_REM:  begin is_div_s = 1'b1; sgn_op_s = 1'b1; is_rem_op_s = 1'b1; end
`endif
        default: is_div_s = 1'b0;
      endcase
    end else begin
      is_div_s = 1'b0;
    end
    dvnd_abs_s = (sgn_op_s && ex.reg1_i[DATA_W-1]) ? (ZERO_W - ex.reg1_i) : ex.reg1_i;
    dvsr_abs_s = (sgn_op_s && ex.reg2_i[DATA_W-1]) ? (ZERO_W - ex.reg2_i) : ex.reg2_i;
  end

  assign div_start_s = (state_r == ST_IDLE) && is_div_s && !ex.flush_i;
  assign shl_s       = {rem_r, quo_r[DATA_W-1]};
  assign diff_s      = shl_s - {1'b0, dvsr_r};
  assign quo_res_s   = neg_q_r   ? (ZERO_W - quo_r) : quo_r;
  assign rem_res_s   = neg_rem_r ? (ZERO_W - rem_r) : rem_r;
  assign shamt_s     = ex.reg1_i[4:0];

  // Divider FSM next state and datapath updates
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    quo_s     = quo_r;
    rem_s     = rem_r;
    dvsr_s    = dvsr_r;
    op_rem_s  = op_rem_r;
    neg_q_s   = neg_q_r;
    neg_rem_s = neg_rem_r;
    if (ex.flush_i) begin
      state_s = ST_IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_start_s) begin
            op_rem_s = is_rem_op_s;
            cnt_s    = CNT_ZERO;
            if (ex.reg2_i == ZERO_W) begin
              // Divide by zero skips iteration: all-ones quotient, raw dividend remainder
              state_s   = ST_DONE;
              quo_s     = ONES_W;
              rem_s     = ex.reg1_i;
              dvsr_s    = ZERO_W;
              neg_q_s   = 1'b0;
              neg_rem_s = 1'b0;
            end else begin
              state_s   = ST_BUSY;
              quo_s     = dvnd_abs_s;
              rem_s     = ZERO_W;
              dvsr_s    = dvsr_abs_s;
              neg_q_s   = sgn_op_s & (ex.reg1_i[DATA_W-1] ^ ex.reg2_i[DATA_W-1]);
              neg_rem_s = sgn_op_s & ex.reg1_i[DATA_W-1];
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          // quo_r doubles as the dividend shift register; quotient bits enter at the LSB
          quo_s   = {quo_r[DATA_W-2:0], ~diff_s[DATA_W]};
          rem_s   = diff_s[DATA_W] ? shl_s[DATA_W-1:0] : diff_s[DATA_W-1:0];
          cnt_s   = cnt_r + CNT_ONE;
          state_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_BUSY;
        end
        ST_DONE: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State and divider registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      quo_r     <= ZERO_W;
      rem_r     <= ZERO_W;
      dvsr_r    <= ZERO_W;
      op_rem_r  <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      quo_r     <= quo_s;
      rem_r     <= rem_s;
      dvsr_r    <= dvsr_s;
      op_rem_r  <= op_rem_s;
      neg_q_r   <= neg_q_s;
      neg_rem_r <= neg_rem_s;
    end
  end

  // Single-cycle ALU result
  always_comb begin
    alu_s = ZERO_W;
    case (ex.alusel_i)
      SEL_LOGIC: begin
        case (ex.aluop_i)
          OP_OR:   alu_s = ex.reg1_i | ex.reg2_i;
          OP_AND:  alu_s = ex.reg1_i & ex.reg2_i;
          OP_XOR:  alu_s = ex.reg1_i ^ ex.reg2_i;
          OP_NOR:  alu_s = ~(ex.reg1_i | ex.reg2_i);
          default: alu_s = ZERO_W;
        endcase
      end
      SEL_SHIFT: begin
        case (ex.aluop_i)
          OP_SLL:  alu_s = ex.reg2_i << shamt_s;
          OP_SRL:  alu_s = ex.reg2_i >> shamt_s;
          OP_SRA:  alu_s = $unsigned($signed(ex.reg2_i) >>> shamt_s);
          default: alu_s = ZERO_W;
        endcase
      end
      SEL_ARITH: begin
        case (ex.aluop_i)
          OP_ADDU: alu_s = ex.reg1_i + ex.reg2_i;
          OP_SUBU: alu_s = ex.reg1_i - ex.reg2_i;
          OP_SLTU: alu_s = {{(DATA_W-1){1'b0}}, (ex.reg1_i < ex.reg2_i)};
          default: alu_s = ZERO_W;
        endcase
      end
      default: alu_s = ZERO_W;
    endcase
  end

  // Output select; write enable is suppressed whenever the stage is stalled or annulled
  always_comb begin
    wd_s    = ex.wd_i;
    wreg_s  = 1'b0;
    wdata_s = ZERO_W;
    stall_s = 1'b0;
    if (rst) begin
      wd_s = 5'd0;
    end else if (ex.flush_i) begin
      wreg_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (div_start_s) begin
            stall_s = 1'b1;
          end else begin
            wreg_s  = (ex.alusel_i != SEL_NOP) & ex.wreg_i;
            wdata_s = alu_s;
          end
        end
        ST_BUSY: stall_s = 1'b1;
        ST_DONE: begin
          wreg_s  = ex.wreg_i;
          wdata_s = op_rem_r ? rem_res_s : quo_res_s;
        end
        default: stall_s = 1'b0;
      endcase
    end
  end

  assign ex.wd_o       = wd_s;
  assign ex.wreg_o     = wreg_s;
  assign ex.wdata_o    = wdata_s;
  assign ex.stallreq_o = stall_s;

endmodule

// File: tb/tb_ex_iter_div.sv
// Scoreboard bench for ex_iter_div: expected results are queued at issue and
// compared when the stage produces an unstalled output.
module tb_ex_iter_div;
  logic clk;
  logic rst;

  ex_iter_div_if #(.DATA_W(32)) bus ();
  ex_iter_div #(.DATA_W(32), .DIV_CNT_W(6)) dut (.clk(clk), .rst(rst), .ex(bus));

  typedef struct { logic [31:0] data; logic [4:0] wd; logic wreg; int stalls; } exp_t;
  typedef struct { logic [7:0] op; logic [2:0] sel; logic [31:0] a; logic [31:0] b; logic [4:0] wd; logic wr; } stim_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wd, input logic wr);
    stim_t s;
    s.op = op; s.sel = sel; s.a = a; s.b = b; s.wd = wd; s.wr = wr;
    return s;
  endfunction

  function automatic logic is_div(input logic [7:0] op, input logic [2:0] sel);
    logic r;
    r = (sel == 3'd4) && (op == 8'h1B || op == 8'h1C);
`ifdef EX_SIGNED_DIV_EN
    r = r || ((sel == 3'd4) && (op == 8'h1A || op == 8'h1D));
`endif
    return r;
  endfunction

  function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'h0;
    case ({sel, op})
      {3'd1, 8'h25}: r = a | b;
      {3'd1, 8'h24}: r = a & b;
      {3'd1, 8'h26}: r = a ^ b;
      {3'd1, 8'h27}: r = ~(a | b);
      {3'd2, 8'h7C}: r = b << a[4:0];
      {3'd2, 8'h02}: r = b >> a[4:0];
      {3'd2, 8'h03}: r = $unsigned($signed(b) >>> a[4:0]);
      {3'd3, 8'h21}: r = a + b;
      {3'd3, 8'h23}: r = a - b;
      {3'd3, 8'h2B}: r = (a < b) ? 32'd1 : 32'd0;
      {3'd4, 8'h1B}: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      {3'd4, 8'h1C}: r = (b == 32'h0) ? a : a % b;
`ifdef EX_SIGNED_DIV_EN
      {3'd4, 8'h1A}: r = (b == 32'h0) ? 32'hFFFF_FFFF :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 :
                         $unsigned($signed(a) / $signed(b));
      {3'd4, 8'h1D}: r = (b == 32'h0) ? a :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 :
                         $unsigned($signed(a) % $signed(b));
`endif
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic nop();
    bus.flush_i = 1'b0; bus.aluop_i = 8'h00; bus.alusel_i = 3'd0;
    bus.reg1_i = 32'h0; bus.reg2_i = 32'h0; bus.wd_i = 5'd0; bus.wreg_i = 1'b0;
  endtask

  task automatic drive_op(input stim_t s);
    exp_t e;
    bus.flush_i = 1'b0; bus.aluop_i = s.op; bus.alusel_i = s.sel;
    bus.reg1_i = s.a; bus.reg2_i = s.b; bus.wd_i = s.wd; bus.wreg_i = s.wr;
    e.data   = model(s.op, s.sel, s.a, s.b);
    e.wd     = s.wd;
    e.wreg   = (s.sel == 3'd0) ? 1'b0 : s.wr;
    e.stalls = !is_div(s.op, s.sel) ? 0 : ((s.b == 32'h0) ? 1 : 33);
    sb.push_back(e);
  endtask

  // Waits (bounded) for the first unstalled cycle; counts stalls and any write-enable leak
  task automatic wait_result(output logic [31:0] d, output logic [4:0] wd, output logic wr,
                             output int stalls, output logic leak, output logic to);
    d = 32'h0; wd = 5'd0; wr = 1'b0; stalls = 0; leak = 1'b0; to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.stallreq_o === 1'b1) begin
        stalls++;
        if (bus.wreg_o !== 1'b0) leak = 1'b1;
        @(posedge clk); #1;
      end else begin
        d = bus.wdata_o; wd = bus.wd_o; wr = bus.wreg_o; to = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    nop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.stallreq_o} !== 39'h0) begin
      n_bad++;
      $display("FAIL reset_during: got wd=%0d wreg=%b wdata=%h stall=%b want all 0",
               bus.wd_o, bus.wreg_o, bus.wdata_o, bus.stallreq_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.stallreq_o} !== 39'h0) begin
      n_bad++;
      $display("FAIL reset_after: got wd=%0d wreg=%b wdata=%h stall=%b want all 0",
               bus.wd_o, bus.wreg_o, bus.wdata_o, bus.stallreq_o);
    end
    @(posedge clk); #1;
  endtask

  // Issues a list of instructions back-to-back and scores each result
  task automatic run_list(input string name, input stim_t tbl[$]);
    logic [31:0] d; logic [4:0] wd; logic wr, lk, to; int st; exp_t e;
    foreach (tbl[i]) begin
      drive_op(tbl[i]);
      wait_result(d, wd, wr, st, lk, to);
      e = sb.pop_front();
      n_cmp++;
      if (d !== e.data) begin
        n_bad++;
        $display("FAIL %s[%0d] wdata: got %h want %h", name, i, d, e.data);
      end
      n_cmp++;
      if ({wd, wr, lk, to} !== {e.wd, e.wreg, 2'b00} || st !== e.stalls) begin
        n_bad++;
        $display("FAIL %s[%0d] ctrl: got wd=%0d wreg=%b stalls=%0d leak=%b timeout=%b want wd=%0d wreg=%b stalls=%0d",
                 name, i, wd, wr, st, lk, to, e.wd, e.wreg, e.stalls);
      end
    end
  endtask

  task automatic test_single_cycle();
    stim_t t[$];
    t.push_back(mk(8'h25, 3'd1, 32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1));
    t.push_back(mk(8'h24, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6, 1'b1));
    t.push_back(mk(8'h26, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd7, 1'b1));
    t.push_back(mk(8'h27, 3'd1, 32'hF0F0_0000, 32'h0000_000F, 5'd8, 1'b1));
    t.push_back(mk(8'h21, 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 5'd9, 1'b1));
    t.push_back(mk(8'h23, 3'd3, 32'h0000_0000, 32'h0000_0001, 5'd10, 1'b1));
    t.push_back(mk(8'h2B, 3'd3, 32'h0000_0001, 32'hFFFF_FFFF, 5'd11, 1'b1));
    t.push_back(mk(8'h2B, 3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd12, 1'b1));
    t.push_back(mk(8'h7C, 3'd2, 32'h0000_0004, 32'h8000_000F, 5'd13, 1'b1));
    t.push_back(mk(8'h02, 3'd2, 32'h0000_001F, 32'h8000_0000, 5'd14, 1'b1));
    t.push_back(mk(8'h03, 3'd2, 32'hFFFF_FFE4, 32'h8000_0000, 5'd15, 1'b1));
    t.push_back(mk(8'h55, 3'd1, 32'h1234_5678, 32'h0000_FFFF, 5'd16, 1'b1));
    t.push_back(mk(8'h25, 3'd0, 32'h1234_5678, 32'h0000_FFFF, 5'd17, 1'b1));
    t.push_back(mk(8'h21, 3'd3, 32'h0000_0003, 32'h0000_0004, 5'd18, 1'b0));
    run_list("single", t);
  endtask

  task automatic test_divide();
    stim_t t[$];
    t.push_back(mk(8'h1B, 3'd4, 32'd100, 32'd7, 5'd1, 1'b1));
    t.push_back(mk(8'h1C, 3'd4, 32'd100, 32'd7, 5'd2, 1'b1));
    t.push_back(mk(8'h1B, 3'd4, 32'h1234_5678, 32'h0, 5'd3, 1'b1));
    t.push_back(mk(8'h1C, 3'd4, 32'h1234_5678, 32'h0, 5'd4, 1'b1));
    t.push_back(mk(8'h1B, 3'd4, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1));
    t.push_back(mk(8'h1B, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1));
    t.push_back(mk(8'h1C, 3'd4, 32'd5, 32'd7, 5'd7, 1'b1));
    t.push_back(mk(8'h1C, 3'd4, 32'hFFFF_FFFF, 32'h8000_0001, 5'd8, 1'b1));
`ifdef EX_SIGNED_DIV_EN
    t.push_back(mk(8'h1A, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1));
    t.push_back(mk(8'h1D, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1));
    t.push_back(mk(8'h1A, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b1));
    t.push_back(mk(8'h1D, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1));
    t.push_back(mk(8'h1A, 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd13, 1'b1));
    t.push_back(mk(8'h1D, 3'd4, 32'hFFFF_FFF9, 32'h0, 5'd14, 1'b1));
`else
    t.push_back(mk(8'h1A, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1));
    t.push_back(mk(8'h1D, 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1));
`endif
    run_list("divide", t);
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    for (int i = 0; i < 6; i++) begin
      t.push_back(mk((i % 2 == 0) ? 8'h1B : 8'h1C, 3'd4, $urandom,
                     (i == 3) ? 32'h0 : ($urandom >> $urandom_range(0, 28)), 5'(i + 20), 1'b1));
    end
    run_list("b2b", t);
  endtask

  task automatic test_flush();
    stim_t t[$];
    drive_op(mk(8'h1B, 3'd4, 32'd1000, 32'd3, 5'd9, 1'b1));
    repeat (11) @(posedge clk);
    #1 bus.flush_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.stallreq_o, bus.wreg_o} !== 2'b00) begin
      n_bad++;
      $display("FAIL flush_cycle: got stall=%b wreg=%b want 0 0", bus.stallreq_o, bus.wreg_o);
    end
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    n_cmp++;
    if ({bus.stallreq_o, bus.wreg_o, bus.wdata_o} !== 34'h0) begin
      n_bad++;
      $display("FAIL flush_next: got stall=%b wreg=%b wdata=%h want 0 0 0", bus.stallreq_o, bus.wreg_o, bus.wdata_o);
    end
    @(posedge clk); #1;
    sb.delete();
    t.push_back(mk(8'h1B, 3'd4, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1));
    run_list("after_flush", t);
  endtask

  task automatic test_reset_mid_divide();
    stim_t t[$];
    drive_op(mk(8'h1B, 3'd4, 32'hDEAD_BEEF, 32'd3, 5'd4, 1'b1));
    repeat (21) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.wd_o, bus.wreg_o, bus.wdata_o, bus.stallreq_o} !== 39'h0) begin
        n_bad++;
        $display("FAIL rst_mid[%0d]: got wd=%0d wreg=%b wdata=%h stall=%b want all 0",
                 k, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.stallreq_o);
      end
      @(posedge clk); #1;
      nop();
      if (k == 1) rst = 1'b0;
    end
    sb.delete();
    t.push_back(mk(8'h1B, 3'd4, 32'hDEAD_BEEF, 32'h0000_1234, 5'd4, 1'b1));
    t.push_back(mk(8'h1C, 3'd4, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5, 1'b1));
    run_list("after_rst", t);
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_divide();
    test_back_to_back();
    test_flush();
    test_reset_mid_divide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
